hazard_unit_n: RTL

Parametrised hazard and forwarding controller for the 5-stage pipelined ARM core. It supersedes the fixed 4-operand, 2-writeback hazard logic. It registers Decode source operands into Execute internally and selects forwarding per operand from any Memory or Writeback write port. It also generates load-use, PC-write and branch stall/flush controls and sequences a multi-cycle Execute unit through a counter-driven FSM. A saturating stall counter is provided for performance debug.

---
 rtl/hazard_unit_n.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hazard_unit_n.sv
// hazard_unit_n: parametrised hazard detection and forwarding controller for the
// 5-stage pipeline. Holds the Execute copy of the Decode operands, picks a
// forwarding source per operand, generates stall/flush controls and sequences
// the multi-cycle Execute unit.
module hazard_unit_n #(
  parameter  int NSRC  = 4,
  parameter  int NWB   = 2,
  parameter  int RW    = 4,
  parameter  int MCLAT = 4,
  localparam int FW    = $clog2(2*NWB+1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NSRC*RW-1:0]  SrcD,
  input  logic [NSRC-1:0]     SrcValidD,
  input  logic [RW-1:0]       DstE0,
  input  logic                RegWriteE0,
  input  logic                MemToRegE,
  input  logic                MultiCycleE,
  input  logic [NWB*RW-1:0]   DstM,
  input  logic [NWB*RW-1:0]   DstW,
  input  logic [NWB-1:0]      RegWriteM,
  input  logic [NWB-1:0]      RegWriteW,
  input  logic                PCSrcD,
  input  logic                PCSrcE,
  input  logic                PCSrcM,
  input  logic                PCSrcW,
  input  logic                BranchTakenE,
  output logic [NSRC*FW-1:0]  ForwardE,
  output logic                StallF,
  output logic                StallD,
  output logic                StallE,
  output logic                FlushD,
  output logic                FlushE,
  output logic                FlushM,
  output logic                Busy,
  output logic [15:0]         StallCnt
);

  localparam int CW = $clog2(MCLAT+1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [NSRC*RW-1:0]  r_SrcE;
  logic [NSRC-1:0]     r_SrcValidE;
  logic [15:0]         r_StallCnt;

  logic [NSRC*FW-1:0]  w_fwd;
  logic                w_hit;
  logic                w_LdStall;
  logic                w_MCStall;
  logic                w_PCWrPend;
  logic                w_StallD;
  logic                w_FlushE;
  logic                w_FlushD;

  // Per-operand forward select: first match in M0..M(n-1), then W0..W(n-1)
  always_comb begin
    w_fwd = '0;
    w_hit = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      w_hit = 1'b0;
      for (int unsigned k = 0; k < NWB; k++) begin
        if (!w_hit && r_SrcValidE[i] && RegWriteM[k] &&
            (r_SrcE[i*RW +: RW] == DstM[k*RW +: RW])) begin
          w_fwd[i*FW +: FW] = FW'(k + 1);
          w_hit = 1'b1;
        end
      end
      for (int unsigned k = 0; k < NWB; k++) begin
        if (!w_hit && r_SrcValidE[i] && RegWriteW[k] &&
            (r_SrcE[i*RW +: RW] == DstW[k*RW +: RW])) begin
          w_fwd[i*FW +: FW] = FW'(NWB + k + 1);
          w_hit = 1'b1;
        end
      end
    end
  end

  // Load-use detection against any valid Decode operand
  always_comb begin
    w_LdStall = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (SrcValidD[i] && (SrcD[i*RW +: RW] == DstE0))
        w_LdStall = 1'b1;
    end
    w_LdStall = w_LdStall & MemToRegE & RegWriteE0;
  end

  assign w_MCStall  = ((r_state == S_IDLE) && MultiCycleE) ||
                      ((r_state == S_BUSY) && (r_cnt > CW'(1)));
  assign w_PCWrPend = PCSrcD | PCSrcE | PCSrcM;
  assign w_StallD   = w_LdStall | w_MCStall;
  assign w_FlushE   = (w_LdStall | BranchTakenE) & ~w_MCStall;
  assign w_FlushD   = (w_PCWrPend | PCSrcW | BranchTakenE) & ~w_StallD;

  // Reset forces a quiet, fully flushed pipeline
  assign ForwardE = reset ? '0 : w_fwd;
  assign StallE   = ~reset & w_MCStall;
  assign StallD   = ~reset & w_StallD;
  assign StallF   = ~reset & (w_StallD | w_PCWrPend);
  assign FlushE   = reset | w_FlushE;
  assign FlushD   = reset | w_FlushD;
  assign FlushM   = reset | w_MCStall;
  assign Busy     = (r_state == S_BUSY);
  assign StallCnt = r_StallCnt;

  // Execute operand registers; a flush loads a bubble by clearing valids
  always_ff @(posedge clk) begin
    if (reset) begin
      r_SrcE      <= '0;
      r_SrcValidE <= '0;
    end else if (!w_MCStall) begin
      r_SrcE      <= SrcD;
      r_SrcValidE <= w_FlushE ? '0 : SrcValidD;
    end
  end

  // Multi-cycle sequencer: the release cycle (cnt==1) returns to IDLE
  // without sampling MultiCycleE, so a held request cannot retrigger
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MultiCycleE) begin
            r_state <= S_BUSY;
            r_cnt   <= CW'(MCLAT - 1);
          end
        end
        S_BUSY: begin
          if (r_cnt > CW'(1)) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Saturating Decode-stall counter
  always_ff @(posedge clk) begin
    if (reset)
      r_StallCnt <= '0;
    else if (w_StallD && (r_StallCnt != 16'hFFFF))
      r_StallCnt <= r_StallCnt + 16'd1;
  end

endmodule
